// File: rtl/alu_responder_if.sv
// Start/done command bus between the ALU driver (master) and the ALU responder (slave).
interface alu_responder_if;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op;
    logic        start;
    logic        done;
    logic [15:0] result;

    modport master (output A, B, op, start, input done, result);
    modport slave  (input A, B, op, start, output done, result);
endinterface

// File: rtl/alu_responder.sv
// ALU responder: accepts one command at a time, single-cycle add/and/xor and
// a fixed-latency multiply, with a one-cycle done pulse and a held result.
module alu_responder #(
    parameter int unsigned MUL_LATENCY = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_responder_if.slave bus
);
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

    state_e      state_q, state_d;
    logic [7:0]  a_q, a_d, b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] result_q, result_d;
    logic        done_q, done_d;
    logic [15:0] alu_res;
    logic        op_valid;

    assign op_valid = (bus.op == OP_ADD) || (bus.op == OP_AND) ||
                      (bus.op == OP_XOR) || (bus.op == OP_MUL);

    // Result is always computed from the latched operands, never the live bus.
    always_comb begin
        alu_res = 16'h0000;
        case (op_q)
            OP_ADD:  alu_res = {7'b0, {1'b0, a_q} + {1'b0, b_q}};
            OP_AND:  alu_res = {8'b0, a_q & b_q};
            OP_XOR:  alu_res = {8'b0, a_q ^ b_q};
            OP_MUL:  alu_res = 16'(a_q) * 16'(b_q);
            default: alu_res = 16'h0000;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && op_valid) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    op_d    = bus.op;
                    cnt_d   = (bus.op == OP_MUL) ? 3'(MUL_LATENCY - 1) : 3'd0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 3'd0) begin
                    result_d = alu_res;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            // start is deliberately not looked at here so a held start is not re-accepted
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            op_q     <= 3'b000;
            cnt_q    <= 3'd0;
            result_q <= 16'h0000;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_alu_responder.sv
// Directed self-checking bench for alu_responder (MUL_LATENCY = 3).
module tb_alu_responder;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    alu_responder_if bus ();

    alu_responder #(.MUL_LATENCY(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle; inputs are changed right after this.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic st);
        bus.A     = a;
        bus.B     = b;
        bus.op    = op;
        bus.start = st;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(8'h00, 8'h00, 3'b000, 1'b0);
        step();
        step();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL reset_done got=%b want=0", bus.done);
        end
        checks++;
        if (bus.result !== 16'h0000) begin
            errors++; $display("FAIL reset_result got=%h want=0000", bus.result);
        end
        rst_n = 1'b1;
        drive(8'h01, 8'h02, 3'b001, 1'b1);
        step();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL reset_accept_edge_done got=%b want=0", bus.done);
        end
        step();
        checks++;
        if (bus.done !== 1'b1 || bus.result !== 16'h0003) begin
            errors++; $display("FAIL reset_first_cmd done=%b result=%h want done=1 result=0003", bus.done, bus.result);
        end
        bus.start = 1'b0;
        step();
    endtask

    task automatic test_add_carry();
        drive(8'hFF, 8'h01, 3'b001, 1'b1);
        step();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL add_accept_done got=%b want=0", bus.done);
        end
        step();
        checks++;
        if (bus.done !== 1'b1 || bus.result !== 16'h0100) begin
            errors++; $display("FAIL add_carry done=%b result=%h want done=1 result=0100", bus.done, bus.result);
        end
        step();
        checks++;
        if (bus.done !== 1'b0 || bus.result !== 16'h0100) begin
            errors++; $display("FAIL add_done_fall done=%b result=%h want done=0 result=0100", bus.done, bus.result);
        end
        // start was held through DONE; a re-accept there would pulse done now
        bus.start = 1'b0;
        step();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL add_no_reaccept done=%b want=0", bus.done);
        end
    endtask

    task automatic test_and_xor();
        drive(8'hF0, 8'h3C, 3'b010, 1'b1);
        step();
        step();
        checks++;
        if (bus.done !== 1'b1 || bus.result !== 16'h0030) begin
            errors++; $display("FAIL and_result done=%b result=%h want done=1 result=0030", bus.done, bus.result);
        end
        bus.op = 3'b011;
        step();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL and_pulse_width done=%b want=0", bus.done);
        end
        step();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL xor_accept_done done=%b want=0", bus.done);
        end
        step();
        checks++;
        if (bus.done !== 1'b1 || bus.result !== 16'h00CC) begin
            errors++; $display("FAIL xor_result done=%b result=%h want done=1 result=00cc", bus.done, bus.result);
        end
        bus.start = 1'b0;
        step();
        checks++;
        if (bus.done !== 1'b0 || bus.result !== 16'h00CC) begin
            errors++; $display("FAIL xor_pulse_width done=%b result=%h want done=0 result=00cc", bus.done, bus.result);
        end
    endtask

    task automatic test_mul_busy_change();
        drive(8'hFF, 8'hFF, 3'b100, 1'b1);
        step();
        bus.A  = 8'h00;
        bus.op = 3'b001;
        step();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL mul_early_1 done=%b want=0", bus.done);
        end
        bus.start = 1'b0;
        step();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL mul_early_2 done=%b want=0", bus.done);
        end
        step();
        checks++;
        if (bus.done !== 1'b1 || bus.result !== 16'hFE01) begin
            errors++; $display("FAIL mul_max done=%b result=%h want done=1 result=fe01", bus.done, bus.result);
        end
        step();
        checks++;
        if (bus.done !== 1'b0 || bus.result !== 16'hFE01) begin
            errors++; $display("FAIL mul_hold done=%b result=%h want done=0 result=fe01", bus.done, bus.result);
        end
    endtask

    task automatic test_noop_reserved();
        logic [2:0] ops [2];
        ops[0] = 3'b000;
        ops[1] = 3'b110;
        for (int i = 0; i < 2; i++) begin
            drive(8'h12, 8'h34, ops[i], 1'b1);
            step();
            bus.start = 1'b0;
            step();
            checks++;
            if (bus.done !== 1'b0 || bus.result !== 16'hFE01) begin
                errors++; $display("FAIL noop_op%0d done=%b result=%h want done=0 result=fe01", ops[i], bus.done, bus.result);
            end
        end
        drive(8'h12, 8'h34, 3'b001, 1'b1);
        step();
        bus.start = 1'b0;
        step();
        checks++;
        if (bus.done !== 1'b1 || bus.result !== 16'h0046) begin
            errors++; $display("FAIL noop_then_add done=%b result=%h want done=1 result=0046", bus.done, bus.result);
        end
        step();
    endtask

    task automatic test_reset_mid_mul();
        int seen;
        drive(8'h10, 8'h10, 3'b100, 1'b1);
        step();
        bus.start = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        checks++;
        if (bus.done !== 1'b0 || bus.result !== 16'h0000) begin
            errors++; $display("FAIL reset_mid_mul done=%b result=%h want done=0 result=0000", bus.done, bus.result);
        end
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.done === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0 || bus.result !== 16'h0000) begin
            errors++; $display("FAIL reset_mid_no_done pulses=%0d result=%h want pulses=0 result=0000", seen, bus.result);
        end
        drive(8'h02, 8'h03, 3'b001, 1'b1);
        step();
        bus.start = 1'b0;
        step();
        checks++;
        if (bus.done !== 1'b1 || bus.result !== 16'h0005) begin
            errors++; $display("FAIL reset_mid_then_add done=%b result=%h want done=1 result=0005", bus.done, bus.result);
        end
        step();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_add_carry();
        test_and_xor();
        test_mul_busy_change();
        test_noop_reserved();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
